// File: rtl/fetch_sequencer.sv
// Program counter owner and fetch sequencer for the 9-bit ISA core.
// Runs the start/done program handshake and counts cycles spent running.
module fetch_sequencer #(
  parameter int              PC_W       = 32,
  parameter logic [PC_W-1:0] START_ADDR = '0,
  parameter int              CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stall,
  input  logic             halt,
  input  logic             branch,
  input  logic             zero,
  input  logic [8:0]       instruction,
  output logic [PC_W-1:0]  pc,
  output logic             fetch_en,
  output logic             done,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [PC_W-1:0]  PC_ONE  = PC_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t          state;
  logic [PC_W-1:0] offset;
  logic [PC_W-1:0] pc_seq;
  logic [1:0]      unused_opcode_bits;

  // Branch offset is always sign-extended from bit 6.
  assign offset             = {{(PC_W-7){instruction[6]}}, instruction[6:0]};
  assign pc_seq             = pc + PC_ONE;
  assign unused_opcode_bits = instruction[8:7];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= START_ADDR;
      cycle_count <= '0;
      fetch_en    <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        IDLE, HALTED: begin
          if (start) begin
            state       <= RUN;
            pc          <= START_ADDR;
            cycle_count <= '0;
            fetch_en    <= 1'b1;
            done        <= 1'b0;
          end
        end
        RUN: begin
          if (cycle_count != '1) begin
            cycle_count <= cycle_count + CNT_ONE;
          end
          // Stall is tested first so unknown branch/zero during a stall never reach pc.
          if (stall) begin
            pc <= pc;
          end else if (halt) begin
            state    <= HALTED;
            fetch_en <= 1'b0;
            done     <= 1'b1;
          end else if (branch && zero) begin
            pc <= pc_seq + offset;
          end else begin
            pc <= pc_seq;
          end
        end
        default: begin
          state    <= IDLE;
          fetch_en <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized and directed bench for fetch_sequencer against an arithmetic reference model.
module tb_fetch_sequencer;
  localparam int PC_W    = 8;
  localparam int CNT_W   = 5;
  localparam int PC_MOD  = 256;
  localparam int CNT_MAX = 31;

  logic             clk = 1'b0;
  logic             reset;
  logic             start, stall, halt, branch, zero;
  logic [8:0]       instruction;
  logic [PC_W-1:0]  pc;
  logic             fetch_en, done;
  logic [CNT_W-1:0] cycle_count;

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0 = idle, 1 = running, 2 = halted.
  int m_mode, m_pc, m_count;

  fetch_sequencer #(.PC_W(PC_W), .START_ADDR(8'd0), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall), .halt(halt),
    .branch(branch), .zero(zero), .instruction(instruction),
    .pc(pc), .fetch_en(fetch_en), .done(done), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  function automatic int sext7(input logic [6:0] v);
    return v[6] ? int'(v) - 128 : int'(v);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_pc = 0; m_count = 0;
  endtask

  task automatic model_edge();
    if (m_mode == 1) begin
      if (m_count < CNT_MAX) m_count++;
      if (stall !== 1'b1) begin
        if (halt === 1'b1) m_mode = 2;
        else if (branch === 1'b1 && zero === 1'b1)
          m_pc = (((m_pc + 1 + sext7(instruction[6:0])) % PC_MOD) + PC_MOD) % PC_MOD;
        else m_pc = (m_pc + 1) % PC_MOD;
      end
    end else if (start === 1'b1) begin
      m_mode = 1; m_pc = 0; m_count = 0;
    end
  endtask

  // Drive one cycle from a falling edge, update the model at the rising edge, return at the next falling edge.
  task automatic step(input logic st, input logic sl, input logic h, input logic b,
                      input logic z, input logic [8:0] ins);
    start = st; stall = sl; halt = h; branch = b; zero = z; instruction = ins;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic plain();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'($urandom));
  endtask

  task automatic take(input logic [6:0] off);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, {2'($urandom), off});
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 0; stall = 0; halt = 0; branch = 0; zero = 0; instruction = '0;
    model_reset();
    @(negedge clk); @(negedge clk);
    checks++; if (pc !== 8'd0) begin errors++; $display("[TB] FAIL reset_pc: got %0h expected 0", pc); end
    checks++; if (fetch_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_fetch_en: got %b expected 0", fetch_en); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    checks++; if (cycle_count !== 5'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", cycle_count); end
    reset = 1'b0;
    plain();
    checks++; if (fetch_en !== 1'b0) begin errors++; $display("[TB] FAIL idle_without_start: got %b expected 0", fetch_en); end
  endtask

  task automatic test_plain();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0);
    checks++; if (pc !== 8'd0) begin errors++; $display("[TB] FAIL start_pc: got %0h expected 0", pc); end
    checks++; if (fetch_en !== 1'b1) begin errors++; $display("[TB] FAIL start_fetch_en: got %b expected 1", fetch_en); end
    for (int i = 1; i <= 5; i++) begin
      plain();
      checks++; if (pc !== 8'(i)) begin errors++; $display("[TB] FAIL plain_pc: got %0d expected %0d", pc, i); end
    end
    checks++; if (cycle_count !== 5'd5) begin errors++; $display("[TB] FAIL plain_count: got %0d expected 5", cycle_count); end
  endtask

  task automatic test_branch();
    for (int i = 0; i < 5; i++) plain();
    checks++; if (pc !== 8'd10) begin errors++; $display("[TB] FAIL branch_setup: got %0d expected 10", pc); end
    take(7'h05);
    checks++; if (pc !== 8'd16) begin errors++; $display("[TB] FAIL branch_fwd: got %0d expected 16", pc); end
    take(7'h79);
    checks++; if (pc !== 8'd10) begin errors++; $display("[TB] FAIL branch_back7: got %0d expected 10", pc); end
    take(7'h7C);
    checks++; if (pc !== 8'd7) begin errors++; $display("[TB] FAIL branch_back4: got %0d expected 7", pc); end
    take(7'h02);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 9'h005);
    checks++; if (pc !== 8'd11) begin errors++; $display("[TB] FAIL branch_not_taken: got %0d expected 11", pc); end
  endtask

  task automatic test_stall();
    int c0;
    take(7'h08);
    checks++; if (pc !== 8'd20) begin errors++; $display("[TB] FAIL stall_setup: got %0d expected 20", pc); end
    c0 = m_count;
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 9'h005);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 9'h07C);
    step(1'b0, 1'b1, 1'b0, 1'bx, 1'bx, 9'h033);
    checks++; if (pc !== 8'd20) begin errors++; $display("[TB] FAIL stall_pc: got %0d expected 20", pc); end
    checks++; if (cycle_count !== 5'(c0 + 3)) begin errors++; $display("[TB] FAIL stall_count: got %0d expected %0d", cycle_count, c0 + 3); end
    checks++; if (fetch_en !== 1'b1) begin errors++; $display("[TB] FAIL stall_fetch_en: got %b expected 1", fetch_en); end
  endtask

  task automatic test_halt();
    take(7'h73);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 9'h005);
    checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL halt_done: got %b expected 1", done); end
    checks++; if (fetch_en !== 1'b0) begin errors++; $display("[TB] FAIL halt_fetch_en: got %b expected 0", fetch_en); end
    checks++; if (pc !== 8'd8) begin errors++; $display("[TB] FAIL halt_pc: got %0d expected 8", pc); end
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 9'h005);
    plain();
    checks++; if (pc !== 8'd8 || done !== 1'b1) begin errors++; $display("[TB] FAIL halt_frozen: got pc %0d done %b expected 8 1", pc, done); end
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 9'h000);
    checks++; if (pc !== 8'd0 || done !== 1'b0 || fetch_en !== 1'b1) begin
      errors++; $display("[TB] FAIL restart: got pc %0d done %b fetch_en %b expected 0 0 1", pc, done, fetch_en); end
    checks++; if (cycle_count !== 5'd0) begin errors++; $display("[TB] FAIL restart_count: got %0d expected 0", cycle_count); end
  endtask

  task automatic test_wrap();
    take(7'h7E);
    checks++; if (pc !== 8'hFF) begin errors++; $display("[TB] FAIL wrap_neg: got %0h expected ff", pc); end
    plain();
    checks++; if (pc !== 8'h00) begin errors++; $display("[TB] FAIL wrap_inc: got %0h expected 0", pc); end
    plain(); plain();
    take(7'h40);
    checks++; if (pc !== 8'hC3) begin errors++; $display("[TB] FAIL wrap_min_offset: got %0h expected c3", pc); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 40; i++) plain();
    checks++; if (cycle_count !== 5'd31) begin errors++; $display("[TB] FAIL count_saturate: got %0d expected 31", cycle_count); end
    checks++; if (pc !== 8'(m_pc)) begin errors++; $display("[TB] FAIL saturate_pc: got %0d expected %0d", pc, m_pc); end
  endtask

  task automatic test_random();
    logic st, sl, h, b, z;
    for (int i = 0; i < 300; i++) begin
      st = ($urandom % 8) == 0;
      sl = ($urandom % 4) == 0;
      h  = ($urandom % 16) == 0;
      b  = 1'($urandom);
      z  = 1'($urandom);
      if (sl && ($urandom % 2 == 0)) begin b = 1'bx; z = 1'bx; end
      step(st, sl, h, b, z, 9'($urandom));
      checks++;
      if (pc !== 8'(m_pc) || fetch_en !== (m_mode == 1) || done !== (m_mode == 2) || cycle_count !== 5'(m_count)) begin
        errors++;
        $display("[TB] FAIL random_cycle%0d: got pc %0d fe %b done %b cnt %0d expected %0d %b %b %0d",
                 i, pc, fetch_en, done, cycle_count, m_pc, m_mode == 1, m_mode == 2, m_count);
      end
    end
  endtask

  task automatic test_reset_mid();
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 9'h000);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000);
    take(7'd29);
    checks++; if (pc !== 8'd30) begin errors++; $display("[TB] FAIL midreset_setup: got %0d expected 30", pc); end
    #2 reset = 1'b1;
    model_reset();
    #1;
    checks++; if (pc !== 8'd0 || fetch_en !== 1'b0 || done !== 1'b0 || cycle_count !== 5'd0) begin
      errors++; $display("[TB] FAIL midreset_immediate: got pc %0d fe %b done %b cnt %0d expected 0 0 0 0", pc, fetch_en, done, cycle_count); end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b0, 1'($urandom), 1'($urandom), 1'b1, 1'b1, 9'h005);
    checks++; if (pc !== 8'd0 || fetch_en !== 1'b0) begin
      errors++; $display("[TB] FAIL midreset_stays_idle: got pc %0d fe %b expected 0 0", pc, fetch_en); end
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000);
    checks++; if (fetch_en !== 1'b1 || pc !== 8'd0) begin
      errors++; $display("[TB] FAIL midreset_restart: got fe %b pc %0d expected 1 0", fetch_en, pc); end
  endtask

  initial begin
    test_reset();
    test_plain();
    test_branch();
    test_stall();
    test_halt();
    test_wrap();
    test_saturation();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
